instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs decoded instruction fields (opcode, registers, funct bits, signed immediate) into a 32-bit RV64I instruction word.
- Used by the instruction-memory loader and the verification stimulus path to build programs.
- Encoding format is inferred from the opcode, and immediates use the same bit placement the decoder expects.
- Two-stage valid/ready pipeline with immediate range checking and error/throughput counters.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter enc_cnt_o.
- ERR_W, 8, width of the saturating error counter err_cnt_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  field bundle valid.
- in_ready_o  out  1  encoder can accept a bundle this cycle.
- opcode_i  in  7  instruction opcode.
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field (R-type only).
- imm_i  in  64  signed immediate, in the same units the immediate generator outputs (B-type is a halfword offset).
- out_valid_o  out  1  instr_o valid.
- out_ready_i  in  1  consumer accepts instr_o.
- instr_o  out  32  encoded instruction.
- err_o  out  1  qualifies instr_o: bundle was unencodable.
- enc_cnt_o  out  CNT_W  instructions emitted, wraps modulo 2^CNT_W.
- err_cnt_o  out  ERR_W  error instructions emitted, saturates at all-ones.

Behaviour:
- Reset values: out_valid_o=0, instr_o=0, err_o=0, enc_cnt_o=0, err_cnt_o=0. in_ready_o is 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards both stages in the same edge; no partial output.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o. Output transfer when out_valid_o & out_ready_i.
  - out_valid_o holds, and instr_o/err_o stay stable, until accepted.
  - in_ready_o = !s1_valid | !s2_valid | out_ready_i (combinational from out_ready_i).
- Pipeline:
  - S1 registers the fields, classifies the format and performs the range check.
  - S2 registers the packed word.
  - Latency is 2 cycles from input transfer to out_valid_o; throughput is 1 per cycle.
  - Holds 2 bundles with out_ready_i low; nothing is dropped or duplicated.
- Format classification (S1) by opcode_i:
  - 0110011 → R.
  - 0010011, 0000011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - Any other opcode → unsupported.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm_i ignored.
  - I: {imm[11:0], rs1, funct3, rd, opcode}; rs2_i and funct7_i ignored.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd_i ignored.
  - B: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
  - B-format imm_i is the halfword offset, so decode(encode(x)) reproduces x.
- Range check for I/S/B: imm_i must satisfy -2048 ≤ imm_i ≤ 2047, i.e. bits [63:11] are all equal.
- Error case (range fail or unsupported opcode): instr_o=32'h00000013 (NOP) with err_o=1.
- Counters update only on an output transfer:
  - enc_cnt_o increments on every transfer, including errors.
  - err_cnt_o increments when err_o=1 and holds at its maximum value.

Optional Feature:
- Macro INSTR_ENC_UJ_EN.
- Defined: adds U-format opcodes 0110111 (lui) and 0010111 (auipc), and J-format opcode 1101111 (jal).
  - U: instr = {imm[19:0], rd, opcode}; range -2^19 ≤ imm_i < 2^19.
  - J: imm_i is a halfword offset h; instr = {h[19], h[9:0], h[10], h[18:11], rd, opcode}; range -2^19 ≤ h < 2^19.
- Undefined: these three opcodes are unsupported and produce NOP with err_o=1.

Test Plan:
- addi: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready_i=1 → instr_o=0x00500093, err_o=0, 2 cycles after transfer; enc_cnt_o=1.
- sd: opcode 0100011, rs1=3, rs2=2, funct3=011, imm=8 → 0x0021B423. beq: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-2 → 0xFE208EE3.
- addi with imm=2048, then opcode 1111111 → both emit 0x00000013 with err_o=1; err_cnt_o=2, enc_cnt_o=2.
- Back-to-back stream of 4 bundles with out_ready_i low for 3 cycles → in_ready_o drops after 2 accepted; all 4 emitted in order, none lost or repeated.
- Reset pulse while 2 bundles are in flight → next cycle out_valid_o=0, both counters 0, in_ready_o=1; a following addi encodes correctly.
- lui: opcode 0110111, rd=5, imm=0x12345 → 0x123452B7 with INSTR_ENC_UJ_EN defined; NOP with err_o=1 without it.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs decoded RV64I fields into a 32-bit instruction word (2-stage pipeline).
// Optional U/J formats (lui, auipc, jal) are enabled by defining INSTR_ENC_UJ_EN.
module instr_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [63:0]      imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] enc_cnt_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_t;

`ifdef INSTR_ENC_UJ_EN
    localparam int IMM_W = 20;
`else
    localparam int IMM_W = 12;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             s1_valid;
    fmt_t             s1_fmt;
    logic             s1_bad;
    logic [6:0]       s1_opcode;
    logic [4:0]       s1_rd;
    logic [4:0]       s1_rs1;
    logic [4:0]       s1_rs2;
    logic [2:0]       s1_funct3;
    logic [6:0]       s1_funct7;
    logic [IMM_W-1:0] s1_imm;

    fmt_t        in_fmt;
    logic        in_bad;
    logic        imm12_ok;
    logic        in_fire;
    logic        out_fire;
    logic        s2_load;
    logic [31:0] s1_word;

    assign in_ready_o = !s1_valid || !out_valid_o || out_ready_i;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;
    assign s2_load    = s1_valid && (!out_valid_o || out_ready_i);

    // Sign-extension check: everything above the field's sign bit must match it.
    assign imm12_ok = (&imm_i[63:11]) || !(|imm_i[63:11]);

`ifdef INSTR_ENC_UJ_EN
    logic imm20_ok;
    assign imm20_ok = (&imm_i[63:19]) || !(|imm_i[63:19]);
`endif

    always_comb begin
        in_fmt = F_X;
        case (opcode_i)
            7'b0110011:             in_fmt = F_R;
            7'b0010011, 7'b0000011: in_fmt = F_I;
            7'b0100011:             in_fmt = F_S;
            7'b1100011:             in_fmt = F_B;
`ifdef INSTR_ENC_UJ_EN
            7'b0110111, 7'b0010111: in_fmt = F_U;
            7'b1101111:             in_fmt = F_J;
`endif
            default:                in_fmt = F_X;
        endcase
    end

    always_comb begin
        in_bad = 1'b1;
        case (in_fmt)
            F_R:           in_bad = 1'b0;
            F_I, F_S, F_B: in_bad = !imm12_ok;
`ifdef INSTR_ENC_UJ_EN
            F_U, F_J:      in_bad = !imm20_ok;
`endif
            default:       in_bad = 1'b1;
        endcase
    end

    // B and J immediates arrive as halfword offsets, so bit n of imm is offset bit n+1.
    always_comb begin
        s1_word = NOP;
        case (s1_fmt)
            F_R: s1_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3,
                            s1_rd, s1_opcode};
            F_I: s1_word = {s1_imm[11:0], s1_rs1, s1_funct3,
                            s1_rd, s1_opcode};
            F_S: s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:0], s1_opcode};
            F_B: s1_word = {s1_imm[11], s1_imm[9:4], s1_rs2, s1_rs1,
                            s1_funct3, s1_imm[3:0], s1_imm[10], s1_opcode};
`ifdef INSTR_ENC_UJ_EN
            F_U: s1_word = {s1_imm[19:0], s1_rd, s1_opcode};
            F_J: s1_word = {s1_imm[19], s1_imm[9:0], s1_imm[10],
                            s1_imm[18:11], s1_rd, s1_opcode};
`endif
            default: s1_word = NOP;
        endcase
        if (s1_bad) begin
            s1_word = NOP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            s1_fmt    <= in_fmt;
            s1_bad    <= in_bad;
            s1_opcode <= opcode_i;
            s1_rd     <= rd_i;
            s1_rs1    <= rs1_i;
            s1_rs2    <= rs2_i;
            s1_funct3 <= funct3_i;
            s1_funct7 <= funct7_i;
            s1_imm    <= imm_i[IMM_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            out_valid_o <= 1'b0;
            instr_o     <= 32'h0;
            err_o       <= 1'b0;
            enc_cnt_o   <= '0;
            err_cnt_o   <= '0;
        end else begin
            if (in_ready_o) begin
                s1_valid <= in_valid_i;
            end
            if (s2_load) begin
                out_valid_o <= 1'b1;
                instr_o     <= s1_word;
                err_o       <= s1_bad;
            end else if (out_fire) begin
                out_valid_o <= 1'b0;
            end
            if (out_fire) begin
                enc_cnt_o <= enc_cnt_o + CNT_W'(1);
                if (err_o && !(&err_cnt_o)) begin
                    err_cnt_o <= err_cnt_o + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: table of encodings plus
// backpressure and mid-flight reset sequences.
module tb_instr_encoder;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;
    localparam int NV = 16;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready_o;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [63:0]      imm;
    logic             out_valid_o;
    logic             out_ready;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [CNT_W-1:0] enc_cnt_o;
    logic [ERR_W-1:0] err_cnt_o;

    int checks = 0;
    int passed = 0;

    vec_t tv[NV];
    vec_t bp[4];
    logic [31:0] got_q[$];
    logic collect = 1'b0;
    logic hold_prev = 1'b0;
    logic [31:0] hold_instr;
    logic hold_err;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .instr_o(instr_o), .err_o(err_o),
        .enc_cnt_o(enc_cnt_o), .err_cnt_o(err_cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic [6:0] op,
                                input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] im,
                                input logic [31:0] ex, input logic ee);
        vec_t v;
        v.name = n; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.f3 = f3; v.f7 = f7; v.imm = im; v.exp = ex; v.exp_err = ee;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    // One bundle through an idle pipe with out_ready high.
    task automatic apply(input vec_t v, input int cnt_before);
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        check({v.name, " in_ready"}, 64'(in_ready_o), 64'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({v.name, " early_valid"}, 64'(out_valid_o), 64'(0));
        tick();
        @(negedge clk);
        check({v.name, " valid"}, 64'(out_valid_o), 64'(1));
        check({v.name, " instr"}, 64'(instr_o), 64'(v.exp));
        check({v.name, " err"}, 64'(err_o), 64'(v.exp_err));
        check({v.name, " enc_cnt"}, 64'(enc_cnt_o), 64'(cnt_before));
        tick();
    endtask

    // Output must hold while stalled; also gathers transfers for ordering checks.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (out_valid_o && instr_o == hold_instr && err_o == hold_err)
                    passed++;
                else
                    $display("FAIL hold: got v=%b %h e=%b expected v=1 %h e=%b",
                             out_valid_o, instr_o, err_o, hold_instr, hold_err);
            end
            hold_prev  = out_valid_o && !out_ready;
            hold_instr = instr_o;
            hold_err   = err_o;
            if (collect && out_valid_o && out_ready) got_q.push_back(instr_o);
        end
    end

    initial begin
        int nerr;
        int accepted;
        int stall_at;
        int cyc;
        int guard;

        tv[0]  = mk("addi", 7'b0010011, 1, 0, 0, 3'b000, 0, 64'd5,
                    32'h00500093, 0);
        tv[1]  = mk("sd", 7'b0100011, 0, 3, 2, 3'b011, 0, 64'd8,
                    32'h0021B423, 0);
        tv[2]  = mk("beq", 7'b1100011, 0, 1, 2, 3'b000, 0, -64'sd2,
                    32'hFE208EE3, 0);
        tv[3]  = mk("add_bigimm", 7'b0110011, 3, 1, 2, 3'b000, 0,
                    64'h8000_0000_0000_0000, 32'h002081B3, 0);
        tv[4]  = mk("sub", 7'b0110011, 3, 1, 2, 3'b000, 7'b0100000, 64'd0,
                    32'h402081B3, 0);
        tv[5]  = mk("addi_2048", 7'b0010011, 1, 0, 0, 3'b000, 0, 64'd2048,
                    32'h00000013, 1);
        tv[6]  = mk("bad_op", 7'b1111111, 1, 2, 3, 3'b000, 0, 64'd0,
                    32'h00000013, 1);
        tv[7]  = mk("addi_m2048", 7'b0010011, 1, 0, 0, 3'b000, 0, -64'sd2048,
                    32'h80000093, 0);
        tv[8]  = mk("addi_2047", 7'b0010011, 1, 0, 0, 3'b000, 0, 64'd2047,
                    32'h7FF00093, 0);
        tv[9]  = mk("lw", 7'b0000011, 5, 2, 0, 3'b010, 0, -64'sd4,
                    32'hFFC12283, 0);
        tv[10] = mk("addi_m2049", 7'b0010011, 1, 0, 0, 3'b000, 0, -64'sd2049,
                    32'h00000013, 1);
        tv[11] = mk("sb_m1", 7'b0100011, 0, 1, 2, 3'b000, 0, -64'sd1,
                    32'hFE208FA3, 0);
        tv[12] = mk("beq_2048", 7'b1100011, 0, 1, 2, 3'b000, 0, 64'd2048,
                    32'h00000013, 1);
`ifdef INSTR_ENC_UJ_EN
        tv[13] = mk("lui", 7'b0110111, 5, 0, 0, 3'b000, 0, 64'h12345,
                    32'h123452B7, 0);
        tv[15] = mk("jal", 7'b1101111, 1, 0, 0, 3'b000, 0, 64'd2,
                    32'h004000EF, 0);
`else
        tv[13] = mk("lui", 7'b0110111, 5, 0, 0, 3'b000, 0, 64'h12345,
                    32'h00000013, 1);
        tv[15] = mk("jal", 7'b1101111, 1, 0, 0, 3'b000, 0, 64'd2,
                    32'h00000013, 1);
`endif
        tv[14] = mk("lui_range", 7'b0110111, 5, 0, 0, 3'b000, 0, 64'h80000,
                    32'h00000013, 1);

        bp[0] = mk("bp0", 7'b0010011, 1, 0, 0, 3'b000, 0, 64'd1, 32'h00100093, 0);
        bp[1] = mk("bp1", 7'b0010011, 2, 0, 0, 3'b000, 0, 64'd2, 32'h00200113, 0);
        bp[2] = mk("bp2", 7'b0010011, 3, 0, 0, 3'b000, 0, 64'd3, 32'h00300193, 0);
        bp[3] = mk("bp3", 7'b0010011, 4, 0, 0, 3'b000, 0, 64'd4, 32'h00400213, 0);

        nerr = 0;
        for (int i = 0; i < NV; i++) nerr += int'(tv[i].exp_err);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(tv[0]);
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst out_valid", 64'(out_valid_o), 64'(0));
        check("rst instr", 64'(instr_o), 64'(0));
        check("rst err", 64'(err_o), 64'(0));
        check("rst enc_cnt", 64'(enc_cnt_o), 64'(0));
        check("rst err_cnt", 64'(err_cnt_o), 64'(0));
        check("rst in_ready", 64'(in_ready_o), 64'(1));
        tick();

        for (int i = 0; i < NV; i++) apply(tv[i], i);
        @(negedge clk);
        check("table enc_cnt", 64'(enc_cnt_o), 64'(NV));
        check("table err_cnt", 64'(err_cnt_o), 64'(nerr));
        tick();

        // Backpressure: out_ready low for the first three cycles.
        got_q.delete();
        collect = 1'b1;
        out_ready = 1'b0;
        accepted = 0;
        stall_at = -1;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(bp[i]);
            in_valid = 1'b1;
            guard = 0;
            @(negedge clk);
            while (!in_ready_o && guard < 20) begin
                if (stall_at < 0) stall_at = accepted;
                tick();
                cyc++;
                out_ready = (cyc >= 3);
                guard++;
                @(negedge clk);
            end
            tick();
            cyc++;
            out_ready = (cyc >= 3);
            accepted++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (got_q.size() < 4 && guard < 50) begin
            tick();
            guard++;
        end
        check("bp stall_after", 64'(stall_at), 64'(2));
        check("bp count", 64'(got_q.size()), 64'(4));
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check({"bp order ", bp[i].name}, 64'(got_q[i]), 64'(bp[i].exp));
        end
        collect = 1'b0;
        @(negedge clk);
        check("bp enc_cnt", 64'(enc_cnt_o), 64'(NV + 4));
        check("bp out_valid idle", 64'(out_valid_o), 64'(0));
        tick();

        // Reset with both stages full.
        out_ready = 1'b0;
        drive(bp[0]);
        in_valid = 1'b1;
        tick();
        drive(bp[1]);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("inflight out_valid", 64'(out_valid_o), 64'(1));
        check("inflight in_ready", 64'(in_ready_o), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst out_valid", 64'(out_valid_o), 64'(0));
        check("mid_rst enc_cnt", 64'(enc_cnt_o), 64'(0));
        check("mid_rst err_cnt", 64'(err_cnt_o), 64'(0));
        check("mid_rst in_ready", 64'(in_ready_o), 64'(1));
        tick();
        out_ready = 1'b1;
        apply(tv[0], 0);
        @(negedge clk);
        check("post_rst enc_cnt", 64'(enc_cnt_o), 64'(1));
        check("post_rst err_cnt", 64'(err_cnt_o), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
